// File: rtl/inv_rotate_controller.sv
// Walks all lanes of the state memory and undoes the encoder's per-lane left rotation.
// Each lane is read, rotated right one bit per cycle by its offset, then written back.
module inv_rotate_controller #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inv_rotate_en,
  input  logic [LANE_W-1:0] mem_rd_data,
  output logic [4:0]        mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [LANE_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              file_write,
  output logic              done
);

  localparam int BW = $clog2(LANE_W);

  typedef enum logic [2:0] {
    IDLE, READ, LOAD, ROT, WRITE, NEXT, FILE_WR, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        lane_q, lane_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [LANE_W-1:0] reg_q, reg_d;
  logic [5:0]        rom_val;
  logic [BW-1:0]     offset;

  // Rotation offsets indexed by lane = x + 5*y.
  always_comb begin
    rom_val = 6'd0;
    case (lane_q)
      5'd0:  rom_val = 6'd0;
      5'd1:  rom_val = 6'd1;
      5'd2:  rom_val = 6'd62;
      5'd3:  rom_val = 6'd28;
      5'd4:  rom_val = 6'd27;
      5'd5:  rom_val = 6'd36;
      5'd6:  rom_val = 6'd44;
      5'd7:  rom_val = 6'd6;
      5'd8:  rom_val = 6'd55;
      5'd9:  rom_val = 6'd20;
      5'd10: rom_val = 6'd3;
      5'd11: rom_val = 6'd10;
      5'd12: rom_val = 6'd43;
      5'd13: rom_val = 6'd25;
      5'd14: rom_val = 6'd39;
      5'd15: rom_val = 6'd41;
      5'd16: rom_val = 6'd45;
      5'd17: rom_val = 6'd15;
      5'd18: rom_val = 6'd21;
      5'd19: rom_val = 6'd8;
      5'd20: rom_val = 6'd18;
      5'd21: rom_val = 6'd2;
      5'd22: rom_val = 6'd61;
      5'd23: rom_val = 6'd56;
      5'd24: rom_val = 6'd14;
      default: rom_val = 6'd0;
    endcase
    offset = BW'(int'(rom_val) % LANE_W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      bit_q   <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      bit_q   <= bit_d;
      reg_q   <= reg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    bit_d   = bit_q;
    reg_d   = reg_q;
    case (state_q)
      IDLE: begin
        lane_d = '0;
        bit_d  = '0;
        if (inv_rotate_en) state_d = READ;
      end
      READ: state_d = LOAD;
      LOAD: begin
        reg_d   = mem_rd_data;
        bit_d   = '0;
        state_d = ROT;
      end
      ROT: begin
        if (bit_q == offset) begin
          state_d = WRITE;
        end else begin
          reg_d = {reg_q[0], reg_q[LANE_W-1:1]};
          bit_d = bit_q + BW'(1);
        end
      end
      WRITE: state_d = NEXT;
      NEXT: begin
        if (lane_q == 5'(NUM_LANES - 1)) begin
          state_d = FILE_WR;
        end else begin
          lane_d  = lane_q + 5'd1;
          state_d = READ;
        end
      end
      FILE_WR: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en  = (state_q == READ);
    mem_wr_en  = (state_q == WRITE);
    file_write = (state_q == FILE_WR);
    done       = (state_q == DONE);
    busy       = (state_q != IDLE);
  end

  assign mem_addr    = lane_q;
  assign mem_wr_data = reg_q;

endmodule
